mem_access_unit: RTL and testbench

Multi-cycle load/store sequencer sitting directly upstream of the data memory in the multi-cycle CPU. It accepts one access request at a time from the control unit, checks alignment and range, and drives the data memory's RW/address/data lines. It performs a read-modify-write for sub-word stores and returns a registered, size-adjusted and optionally sign-extended load result. The data memory is byte-addressed, big-endian, asynchronous-read and level-triggered on write, so this block owns all glitch-free sequencing of `DataMemRW`.

---
 rtl/mem_pkg.sv | 51 +++++
 rtl/mem_access_unit_if.sv | 30 +++
 rtl/byte_lane_align.sv | 83 ++++++++
 rtl/mem_access_unit.sv | 164 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the data-memory load/store sequencer.
// Sizes, FSM states and alignment/range checks used by the unit and its lane aligner.
package mem_pkg;

    localparam int unsigned MEM_BYTES_DEFAULT = 32'd64;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RD   = 2'b01,
        S_WR   = 2'b10,
        S_DONE = 2'b11
    } state_e;

    function automatic logic [2:0] size_bytes(input size_e sz);
        logic [2:0] n;
        case (sz)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] off);
        logic m;
        case (sz)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = off[0];
            SZ_WORD: m = (off != 2'b00);
            default: m = 1'b1;
        endcase
        return m;
    endfunction

    // The 33-bit sum keeps addresses near 2^32 from wrapping back into range.
    function automatic logic out_of_range(input logic [31:0] addr, input size_e sz,
                                          input int unsigned mem_bytes);
        logic [32:0] end_s;
        end_s = {1'b0, addr} + {30'd0, size_bytes(sz)};
        return (end_s > 33'(mem_bytes));
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bus of the load/store sequencer.
// slave: the sequencer's view; master: control unit plus data memory.
interface mem_access_unit_if;

    logic        start;
    logic        is_store;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        DataMemRW;
    logic [31:0] DAddr;
    logic [31:0] DataIn;
    logic [31:0] DataOut;

    modport slave (
        input  start, is_store, size, sign_ext, addr, wdata, DataOut,
        output busy, done, err, rdata, DataMemRW, DAddr, DataIn
    );

    modport master (
        output start, is_store, size, sign_ext, addr, wdata, DataOut,
        input  busy, done, err, rdata, DataMemRW, DAddr, DataIn
    );

endinterface

// File: rtl/byte_lane_align.sv
// Big-endian lane extraction/extension for loads and lane merge for sub-word stores.
// Purely combinational so it can sit behind any word-wide memory port.
module byte_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  size_e       size_i,
    input  logic        sign_ext_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and half; offset 0 is the most significant lane.
    always_comb begin
        byte_s = 8'd0;
        case (offset_i)
            2'd0:    byte_s = word_i[31:24];
            2'd1:    byte_s = word_i[23:16];
            2'd2:    byte_s = word_i[15:8];
            2'd3:    byte_s = word_i[7:0];
            default: byte_s = 8'd0;
        endcase
        if (offset_i[1]) begin
            half_s = word_i[15:0];
        end else begin
            half_s = word_i[31:16];
        end
    end

    // Right-align the selected lane and extend it to 32 bits.
    always_comb begin
        load_o = 32'd0;
        case (size_i)
            SZ_BYTE: begin
                if (sign_ext_i) begin
                    load_o = {{24{byte_s[7]}}, byte_s};
                end else begin
                    load_o = {24'd0, byte_s};
                end
            end
            SZ_HALF: begin
                if (sign_ext_i) begin
                    load_o = {{16{half_s[15]}}, half_s};
                end else begin
                    load_o = {16'd0, half_s};
                end
            end
            SZ_WORD: load_o = word_i;
            default: load_o = 32'd0;
        endcase
    end

    // Replace only the target lane(s) of the captured word with store data.
    always_comb begin
        merge_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                case (offset_i)
                    2'd0:    merge_o[31:24] = wdata_i[7:0];
                    2'd1:    merge_o[23:16] = wdata_i[7:0];
                    2'd2:    merge_o[15:8]  = wdata_i[7:0];
                    2'd3:    merge_o[7:0]   = wdata_i[7:0];
                    default: merge_o = word_i;
                endcase
            end
            SZ_HALF: begin
                if (offset_i[1]) begin
                    merge_o[15:0] = wdata_i[15:0];
                end else begin
                    merge_o[31:16] = wdata_i[15:0];
                end
            end
            SZ_WORD: merge_o = wdata_i;
            default: merge_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store sequencer in front of a big-endian, async-read data memory.
// All memory-side outputs come straight from flops so DataMemRW never glitches.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic              CLK,
    input  logic              Reset,
    mem_access_unit_if.slave  bus
);

    state_e      state_q, state_d;
    logic        is_store_q, is_store_d;
    size_e       size_q, size_d;
    logic        sign_ext_q, sign_ext_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rw_q, rw_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] datain_q, datain_d;

    size_e       req_size_s;
    logic        req_err_s;
    logic [31:0] load_s;
    logic [31:0] merge_s;

    assign req_size_s = size_e'(bus.size);
    assign req_err_s  = misaligned(req_size_s, bus.addr[1:0]) ||
                        out_of_range(bus.addr, req_size_s, MEM_BYTES);

    byte_lane_align u_align (
        .word_i     (bus.DataOut),
        .offset_i   (off_q),
        .size_i     (size_q),
        .sign_ext_i (sign_ext_q),
        .wdata_i    (wdata_q),
        .load_o     (load_s),
        .merge_o    (merge_s)
    );

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        size_d     = size_q;
        sign_ext_d = sign_ext_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        rw_d       = rw_q;
        daddr_d    = daddr_q;
        datain_d   = datain_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    is_store_d = bus.is_store;
                    size_d     = req_size_s;
                    sign_ext_d = bus.sign_ext;
                    off_d      = bus.addr[1:0];
                    wdata_d    = bus.wdata;
                    if (req_err_s) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (bus.is_store && (req_size_s == SZ_WORD)) begin
                        state_d  = S_WR;
                        busy_d   = 1'b1;
                        rw_d     = 1'b1;
                        daddr_d  = {bus.addr[31:2], 2'b00};
                        datain_d = bus.wdata;
                    end else begin
                        // Loads and sub-word stores both need the current word first.
                        state_d = S_RD;
                        busy_d  = 1'b1;
                        daddr_d = {bus.addr[31:2], 2'b00};
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (is_store_q) begin
                    state_d  = S_WR;
                    rw_d     = 1'b1;
                    datain_d = merge_s;
                end else begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    rdata_d = load_s;
                end
            end
            S_WR: begin
                state_d = S_DONE;
                rw_d    = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b0;
                err_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                err_d   = 1'b0;
                rw_d    = 1'b0;
            end
        endcase
    end

    // State, request latches and registered outputs; reset clears everything at once.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            size_q     <= SZ_BYTE;
            sign_ext_q <= 1'b0;
            off_q      <= 2'd0;
            wdata_q    <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            rw_q       <= 1'b0;
            daddr_q    <= 32'd0;
            datain_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            size_q     <= size_d;
            sign_ext_q <= sign_ext_d;
            off_q      <= off_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            rw_q       <= rw_d;
            daddr_q    <= daddr_d;
            datain_q   <= datain_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.DataMemRW = rw_q;
    assign bus.DAddr     = daddr_q;
    assign bus.DataIn    = datain_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 16-word behavioural data memory.
module tb_mem_access_unit;

    logic CLK;
    logic Reset;
    int   total;
    int   bad;
    int   done_cnt;
    int   wr_cycles;
    int   overlap;
    int   lat;
    logic e;
    int   d0;
    int   w0;

    logic [31:0] mem [16];

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign bus.DataOut = mem[bus.DAddr[5:2]];

    always @(posedge CLK) begin
        if (bus.DataMemRW) mem[bus.DAddr[5:2]] <= bus.DataIn;
    end

    always @(negedge CLK) begin
        if (bus.done) done_cnt++;
        if (bus.DataMemRW) wr_cycles++;
        if (bus.done && bus.busy) overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE, scramble inputs after acceptance, measure latency.
    task automatic issue(input logic st, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int l, output logic er);
        bus.is_store = st;
        bus.size     = sz;
        bus.sign_ext = sx;
        bus.addr     = a;
        bus.wdata    = wd;
        bus.start    = 1'b1;
        @(posedge CLK); #1;
        bus.start    = 1'b0;
        bus.is_store = ~st;
        bus.sign_ext = ~sx;
        bus.addr     = 32'hFFFF_FFFD;
        bus.wdata    = ~wd;
        l = 1;
        while (!bus.done && l < 10) begin
            @(posedge CLK); #1;
            l++;
        end
        er = bus.err;
        @(posedge CLK); #1;
    endtask

    initial begin
        total = 0; bad = 0; done_cnt = 0; wr_cycles = 0; overlap = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        Reset = 1'b0;
        bus.start = 1'b0; bus.is_store = 1'b0; bus.size = 2'b00;
        bus.sign_ext = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0;
        #12;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        chk("rst_rw", {31'd0, bus.DataMemRW}, 32'd0);
        chk("rst_daddr", bus.DAddr, 32'd0);
        chk("rst_datain", bus.DataIn, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        #10 Reset = 1'b1;
        @(posedge CLK); #1;

        // Word round trip
        w0 = wr_cycles;
        issue(1'b1, 2'b10, 1'b0, 32'd8, 32'h1234_5678, lat, e);
        chk("st_word_lat", lat, 32'd2);
        chk("st_word_err", {31'd0, e}, 32'd0);
        chk("st_word_pulse", wr_cycles - w0, 32'd1);
        chk("st_word_mem", mem[2], 32'h1234_5678);
        issue(1'b0, 2'b10, 1'b0, 32'd8, 32'd0, lat, e);
        chk("ld_word_lat", lat, 32'd2);
        chk("ld_word_err", {31'd0, e}, 32'd0);
        chk("ld_word_data", bus.rdata, 32'h1234_5678);

        // Sub-word store merge
        issue(1'b1, 2'b10, 1'b0, 32'd4, 32'hAABB_CCDD, lat, e);
        w0 = wr_cycles;
        issue(1'b1, 2'b00, 1'b0, 32'd6, 32'h0000_0011, lat, e);
        chk("st_byte_lat", lat, 32'd3);
        chk("st_byte_pulse", wr_cycles - w0, 32'd1);
        chk("st_byte_rdata_kept", bus.rdata, 32'h1234_5678);
        issue(1'b0, 2'b10, 1'b0, 32'd4, 32'd0, lat, e);
        chk("st_byte_merge", bus.rdata, 32'hAABB_11DD);
        issue(1'b1, 2'b01, 1'b0, 32'd10, 32'h0000_BEEF, lat, e);
        chk("st_half_lat", lat, 32'd3);
        chk("st_half_merge", mem[2], 32'h1234_BEEF);

        // Loads with extension
        issue(1'b1, 2'b10, 1'b0, 32'd12, 32'h80FF_7F01, lat, e);
        issue(1'b0, 2'b00, 1'b1, 32'd12, 32'd0, lat, e);
        chk("ld_byte_sx", bus.rdata, 32'hFFFF_FF80);
        issue(1'b0, 2'b00, 1'b0, 32'd12, 32'd0, lat, e);
        chk("ld_byte_zx", bus.rdata, 32'h0000_0080);
        issue(1'b0, 2'b01, 1'b1, 32'd14, 32'd0, lat, e);
        chk("ld_half_sx", bus.rdata, 32'h0000_7F01);
        issue(1'b0, 2'b01, 1'b1, 32'd12, 32'd0, lat, e);
        chk("ld_half0_sx", bus.rdata, 32'hFFFF_80FF);
        issue(1'b0, 2'b00, 1'b1, 32'd13, 32'd0, lat, e);
        chk("ld_byte1_sx", bus.rdata, 32'hFFFF_FFFF);

        // Errors
        w0 = wr_cycles;
        issue(1'b1, 2'b01, 1'b0, 32'd3, 32'h0000_5555, lat, e);
        chk("err_half_lat", lat, 32'd1);
        chk("err_half_err", {31'd0, e}, 32'd1);
        chk("err_half_nowr", wr_cycles - w0, 32'd0);
        chk("err_half_rdata", bus.rdata, 32'hFFFF_FFFF);
        issue(1'b0, 2'b10, 1'b0, 32'd64, 32'd0, lat, e);
        chk("err_range_err", {31'd0, e}, 32'd1);
        chk("err_range_rdata", bus.rdata, 32'hFFFF_FFFF);
        issue(1'b0, 2'b11, 1'b0, 32'd0, 32'd0, lat, e);
        chk("err_size11", {31'd0, e}, 32'd1);
        issue(1'b0, 2'b00, 1'b0, 32'd63, 32'd0, lat, e);
        chk("edge_byte63_err", {31'd0, e}, 32'd0);
        chk("err_cleared", {31'd0, bus.err}, 32'd0);

        // Ignored start held through RD and WR
        d0 = done_cnt; w0 = wr_cycles;
        bus.is_store = 1'b1; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.addr = 32'd5; bus.wdata = 32'h0000_0022; bus.start = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        chk("ign_done_count", done_cnt - d0, 32'd1);
        chk("ign_wr_count", wr_cycles - w0, 32'd1);
        issue(1'b0, 2'b10, 1'b0, 32'd4, 32'd0, lat, e);
        chk("ign_merge", bus.rdata, 32'hAA22_11DD);

        // Reset during WR of a byte store
        bus.is_store = 1'b1; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.addr = 32'd9; bus.wdata = 32'h0000_0033; bus.start = 1'b1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        @(posedge CLK); #1;
        chk("rst_mid_rw_before", {31'd0, bus.DataMemRW}, 32'd1);
        #2 Reset = 1'b0;
        #1;
        chk("rst_mid_rw_after", {31'd0, bus.DataMemRW}, 32'd0);
        chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mid_rdata", bus.rdata, 32'd0);
        #3 Reset = 1'b1;
        @(posedge CLK); #1;
        issue(1'b0, 2'b10, 1'b0, 32'd8, 32'd0, lat, e);
        chk("post_rst_lat", lat, 32'd2);
        chk("post_rst_data", bus.rdata, 32'h1234_BEEF);

        chk("busy_done_overlap", overlap, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
